sar_adc_ctrl: RTL and testbench

Successive-approximation ADC controller: the read-back counterpart to the 10-bit AVSDDAC output path in alphasoc. It drives a WIDTH-bit trial code into a DAC, samples an external comparator each cycle, and resolves one bit per clock, MSB first. It sits on the PLL-derived core clock beside alphacore. The core issues `start` and reads `result` when `done` pulses.

---
 rtl/sar_adc_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl -- successive-approximation ADC controller.
// Drives a WIDTH-bit trial code into the DAC and samples the external
// comparator once per cycle. It resolves one bit per clock, MSB first.
//
// Optional feature macro: SAR_AVG4_EN
//   When defined, one accepted start runs four SAMPLE+CONVERT passes.
//   The reported result is the truncated mean of the four codes.
//
// Ports:
//   clk       core clock
//   reset     synchronous, active-high reset
//   start     conversion request, sampled only in IDLE
//   cmp_in    comparator: 1 when the analog input >= DAC output for dac_code
//   dac_code  trial code to the DAC
//   sample    track/hold enable
//   busy      high from start acceptance through the last bit decision
//   done      one-cycle pulse when result updates
//   result    last completed conversion, held until the next completion
//   valid     set at the first done, cleared only by reset
module sar_adc_ctrl #(
   parameter int unsigned WIDTH         = 10,
   parameter int unsigned SAMPLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cmp_in,
   output logic [WIDTH-1:0] dac_code,
   output logic             sample,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             valid
);

   localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0]    SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
   localparam logic [WIDTH-1:0] MSB_CODE    = WIDTH'(1) << (WIDTH - 1);
   localparam logic [KW-1:0]    K_TOP       = KW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAMPLE  = 2'd1,
      ST_CONVERT = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] dac_code_d;
   logic             sample_d, busy_d, done_d, valid_d;
   logic [WIDTH-1:0] result_d;
   logic [WIDTH-1:0] resolved;
   logic             last_sample, last_bit, last_pass;

`ifdef SAR_AVG4_EN
   logic [WIDTH+1:0] acc_q, acc_d, acc_sum;
   logic [1:0]       pass_q, pass_d;

   assign last_pass = (pass_q == 2'd3);
   assign acc_sum   = acc_q + (WIDTH+2)'(resolved);
`else
   assign last_pass = 1'b1;
`endif

   assign last_sample = (cnt_q == SAMPLE_LAST);
   assign last_bit    = (k_q == '0);

   // Working code after this cycle's decision: bit k takes the comparator
   // result and, unless k is the LSB, the next lower bit becomes the trial.
   always_comb begin
      resolved      = dac_code;
      resolved[k_q] = cmp_in;
      if (!last_bit) begin
         resolved[k_q - KW'(1)] = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (last_sample) state_d = ST_CONVERT;
         end
         ST_CONVERT: begin
            if (last_bit) state_d = last_pass ? ST_DONE : ST_SAMPLE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output / datapath next values, registered below
   always_comb begin
      dac_code_d = dac_code;
      sample_d   = 1'b0;
      busy_d     = busy;
      done_d     = 1'b0;
      result_d   = result;
      valid_d    = valid;
      cnt_d      = cnt_q;
      k_d        = k_q;
`ifdef SAR_AVG4_EN
      acc_d      = acc_q;
      pass_d     = pass_q;
`endif
      case (state_q)
         ST_IDLE: begin
            dac_code_d = '0;
            busy_d     = 1'b0;
            if (start) begin
               sample_d = 1'b1;
               busy_d   = 1'b1;
               cnt_d    = '0;
`ifdef SAR_AVG4_EN
               acc_d    = '0;
               pass_d   = '0;
`endif
            end
         end
         ST_SAMPLE: begin
            sample_d = 1'b1;
            cnt_d    = cnt_q + CW'(1);
            if (last_sample) begin
               sample_d   = 1'b0;
               dac_code_d = MSB_CODE;
               k_d        = K_TOP;
            end
         end
         ST_CONVERT: begin
            dac_code_d = resolved;
            if (!last_bit) begin
               k_d = k_q - KW'(1);
            end else begin
`ifdef SAR_AVG4_EN
               acc_d = acc_sum;
               if (last_pass) begin
                  result_d = acc_sum[WIDTH+1:2];
                  done_d   = 1'b1;
                  valid_d  = 1'b1;
                  busy_d   = 1'b0;
               end else begin
                  // Straight into the next pass's track/hold window.
                  pass_d     = pass_q + 2'd1;
                  cnt_d      = '0;
                  sample_d   = 1'b1;
                  dac_code_d = '0;
               end
`else
               result_d = resolved;
               done_d   = 1'b1;
               valid_d  = 1'b1;
               busy_d   = 1'b0;
`endif
            end
         end
         ST_DONE: begin
            dac_code_d = '0;
            busy_d     = 1'b0;
         end
         default: begin
            dac_code_d = '0;
            busy_d     = 1'b0;
         end
      endcase
   end

   // Registered outputs and datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         dac_code <= '0;
         sample   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         valid    <= 1'b0;
         cnt_q    <= '0;
         k_q      <= '0;
`ifdef SAR_AVG4_EN
         acc_q    <= '0;
         pass_q   <= '0;
`endif
      end else begin
         dac_code <= dac_code_d;
         sample   <= sample_d;
         busy     <= busy_d;
         done     <= done_d;
         result   <= result_d;
         valid    <= valid_d;
         cnt_q    <= cnt_d;
         k_q      <= k_d;
`ifdef SAR_AVG4_EN
         acc_q    <= acc_d;
         pass_q   <= pass_d;
`endif
      end
   end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl -- self-checking bench for sar_adc_ctrl.
// The comparator is modelled as (vin_code >= dac_code). Expected trial codes
// come from a plain binary search over the bit positions. The expected result
// is the integer mean of the per-pass codes.
module tb_sar_adc_ctrl;

   localparam int unsigned W = 10;
   localparam int unsigned S = 2;
`ifdef SAR_AVG4_EN
   localparam int unsigned PASSES = 4;
`else
   localparam int unsigned PASSES = 1;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         cmp_in;
   logic [W-1:0] dac_code;
   logic         sample;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         valid;

   logic [W-1:0] vin_code;
   logic [W-1:0] last_result;
   logic [W-1:0] rv [4];
   int           tests = 0;
   int           fails = 0;

   assign cmp_in = (vin_code >= dac_code);

   always #5 clk = ~clk;

   sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .cmp_in   (cmp_in),
      .dac_code (dac_code),
      .sample   (sample),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .valid    (valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_dac"},    32'(dac_code), 32'(0));
      check({tag, "_sample"}, 32'(sample),   32'(0));
      check({tag, "_busy"},   32'(busy),     32'(0));
      check({tag, "_done"},   32'(done),     32'(0));
      check({tag, "_result"}, 32'(result),   32'(0));
      check({tag, "_valid"},  32'(valid),    32'(0));
   endtask

   // One full conversion from an IDLE cycle. poke pulses start while busy;
   // hold leaves start high throughout so the next call re-triggers.
   task automatic run_conv(input logic [W-1:0] vins [4], input bit poke, input bit hold);
      logic [W-1:0] code;
      logic [W-1:0] trial;
      int unsigned  sum;
      sum   = 0;
      code  = '0;
      start = 1'b1;
      tick();
      if (!hold) start = 1'b0;
      for (int p = 0; p < int'(PASSES); p++) begin
         vin_code = vins[p];
         code     = '0;
         for (int s = 0; s < int'(S); s++) begin
            check("samp_sample", 32'(sample), 32'(1));
            check("samp_busy",   32'(busy),   32'(1));
            check("samp_done",   32'(done),   32'(0));
            if (poke && s == 0) start = 1'b1;
            tick();
            if (!hold) start = 1'b0;
         end
         for (int i = int'(W) - 1; i >= 0; i--) begin
            trial = code | (W'(1) << i);
            check("conv_dac",    32'(dac_code), 32'(trial));
            check("conv_sample", 32'(sample),   32'(0));
            check("conv_busy",   32'(busy),     32'(1));
            check("conv_done",   32'(done),     32'(0));
            if (vin_code >= trial) code = trial;
            if (poke && i == int'(W) / 2) start = 1'b1;
            tick();
            if (!hold) start = 1'b0;
         end
         sum += 32'(code);
      end
      check("done_pulse",  32'(done),     32'(1));
      check("done_result", 32'(result),   sum / PASSES);
      check("done_valid",  32'(valid),    32'(1));
      check("done_busy",   32'(busy),     32'(0));
      check("done_dac",    32'(dac_code), 32'(code));
      check("done_sample", 32'(sample),   32'(0));
      last_result = W'(sum / PASSES);
      tick();
      check("idle_done",   32'(done),     32'(0));
      check("idle_busy",   32'(busy),     32'(0));
      check("idle_sample", 32'(sample),   32'(0));
      check("idle_dac",    32'(dac_code), 32'(0));
      check("idle_result", 32'(result),   32'(last_result));
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      vin_code = '0;
      tick();
      tick();
      check_reset_values("por");
      reset = 1'b0;
      tick();
      check_reset_values("idle0");

      // Full scale, zero, and the reference input
      run_conv('{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}, 1'b0, 1'b0);
      run_conv('{10'h000, 10'h000, 10'h000, 10'h000}, 1'b0, 1'b0);
      run_conv('{10'h2A5, 10'h2A5, 10'h2A5, 10'h2A5}, 1'b0, 1'b0);
      check("ref_result", 32'(result), 32'h2A5);

      // start pulses while busy must not queue a second conversion
      run_conv('{10'h155, 10'h155, 10'h155, 10'h155}, 1'b1, 1'b0);
      tick();
      check("noqueue_sample", 32'(sample), 32'(0));
      check("noqueue_busy",   32'(busy),   32'(0));

      // Held start: back-to-back with one IDLE cycle in between
      run_conv('{10'h0F0, 10'h0F0, 10'h0F0, 10'h0F0}, 1'b0, 1'b1);
      run_conv('{10'h30F, 10'h30F, 10'h30F, 10'h30F}, 1'b0, 1'b1);
      start = 1'b0;
      tick();

`ifdef SAR_AVG4_EN
      run_conv('{10'h100, 10'h101, 10'h102, 10'h103}, 1'b0, 1'b0);
      check("avg_result", 32'(result), 32'h101);
`endif

      // Randomized inputs
      for (int n = 0; n < 6; n++) begin
         for (int j = 0; j < 4; j++) rv[j] = W'($urandom_range(0, (1 << W) - 1));
         run_conv(rv, 1'b0, 1'b0);
      end

      // Reset mid-conversion: aborts, no done, result/valid cleared
      vin_code = 10'h1C3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (S + 3) tick();
      check("pre_rst_busy", 32'(busy), 32'(1));
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rst_no_done", 32'(done), 32'(0));
      end
      check_reset_values("midrst");
      reset = 1'b0;
      tick();
      check_reset_values("postrst");

      // Recovery after reset
      for (int j = 0; j < 4; j++) rv[j] = W'($urandom_range(0, (1 << W) - 1));
      run_conv(rv, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
